// File: rtl/matmul_host_seq.sv
// Host-side sequencer for the 3x3 matrix-vector multiplier: streams 12 staged words out, collects 3 results.
// Optional idle-handshake timeout enabled by defining MATMUL_HOST_TIMEOUT_EN.
module matmul_host_seq #(
  parameter int DATA_W      = 8,
  parameter int RES_W       = 18,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stage_wr_en,
  input  logic [3:0]        stage_addr,
  input  logic [DATA_W-1:0] stage_wdata,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [1:0]        res_rd_addr,
  output logic [RES_W-1:0]  res_rd_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [RES_W-1:0]  rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SEND_W = 3'd1;
  localparam logic [2:0] ST_SEND_X = 3'd2;
  localparam logic [2:0] ST_RECV   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]        state;
  logic [3:0]        tx_idx;
  logic [1:0]        rx_idx;
  logic [DATA_W-1:0] staging [12];
  logic [RES_W-1:0]  result  [3];
  logic              tx_fire;
  logic              rx_fire;
  logic              timeout;

  // Handshake outputs come only from the registered state, never from tx_ready/rx_valid.
  assign busy     = (state == ST_SEND_W) || (state == ST_SEND_X) || (state == ST_RECV);
  assign tx_valid = (state == ST_SEND_W) || (state == ST_SEND_X);
  assign rx_ready = (state == ST_RECV);
  assign done     = (state == ST_DONE);
  assign tx_data  = staging[tx_idx];
  assign tx_fire  = tx_valid && tx_ready;
  assign rx_fire  = rx_valid && rx_ready;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    res_rd_data = '0;
    if (res_rd_addr != 2'd3) res_rd_data = result[res_rd_addr];
  end

`ifdef MATMUL_HOST_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] wait_cnt;

  // The cycle that would bring the count to TIMEOUT_CYC aborts the run instead.
  assign timeout = busy && !tx_fire && !rx_fire && (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (!busy || tx_fire || rx_fire || timeout) wait_cnt <= '0;
      else                                        wait_cnt <= wait_cnt + 1'b1;
      if (timeout)                            err <= 1'b1;
      else if ((state == ST_IDLE) && start)   err <= 1'b0;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      tx_idx <= '0;
      rx_idx <= '0;
      // NOTE: the staging and result arrays are reset explicitly because a reset must leave them readable as zero.
      for (int i = 0; i < 12; i++) staging[i] <= '0;
      for (int i = 0; i < 3; i++)  result[i]  <= '0;
    end else if (timeout) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (stage_wr_en && (stage_addr < 4'd12)) staging[stage_addr] <= stage_wdata;
          if (start) begin
            state  <= ST_SEND_W;
            tx_idx <= '0;
          end
        end
        ST_SEND_W: begin
          if (tx_fire) begin
            tx_idx <= tx_idx + 1'b1;
            if (tx_idx == 4'd8) state <= ST_SEND_X;
          end
        end
        ST_SEND_X: begin
          if (tx_fire) begin
            tx_idx <= tx_idx + 1'b1;
            if (tx_idx == 4'd11) begin
              state  <= ST_RECV;
              rx_idx <= '0;
            end
          end
        end
        ST_RECV: begin
          if (rx_fire) begin
            result[rx_idx] <= rx_data;
            rx_idx         <= rx_idx + 1'b1;
            if (rx_idx == 2'd2) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
